tx_rotator: RTL and testbench

Transmit-side complex rotator for the MSK modem: multiplies baseband I/Q by e^(+jθ) to shift it onto the IF carrier, which is the counterpart of the receive derotator. It contains its own phase accumulator (NCO) and a quarter-wave cos/sin table, is fully synthesizable, and is pipelined with valid/ready handshakes. It sits between the TX pulse shaper and the DAC interface.

---
 rtl/msk_tx_pkg.sv | 31 +++
 rtl/tx_sincos_lut.sv | 70 +++++++
 rtl/tx_rotator.sv | 108 ++++++++++
 tb/tb_tx_rotator.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/msk_tx_pkg.sv
// Shared definitions for the MSK transmit datapath: default widths, rounding
// and saturation helpers, and the quadrant encoding used by the sin/cos table.
package msk_tx_pkg;

    localparam int WIDTH_DEF       = 16;
    localparam int DDS_WIDTH_DEF   = 16;
    localparam int PHASE_WIDTH_DEF = 32;
    localparam int LUT_ADDR_W_DEF  = 10;

    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quadrant_t;

    // Half an output LSB once the product is shifted right by dds_width-1.
    function automatic logic signed [63:0] round_const(input int dds_width);
        return 64'sd1 <<< (dds_width - 2);
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                    input int               width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/tx_sincos_lut.sv
// Quarter-wave cos/sin table with registered outputs; the stored quarter is
// built at elaboration and mirrored/negated per quadrant.
module tx_sincos_lut
    import msk_tx_pkg::*;
#(
    parameter int DDS_WIDTH  = DDS_WIDTH_DEF,
    parameter int LUT_ADDR_W = LUT_ADDR_W_DEF
) (
    input  logic                        clk,
    input  logic                        en,
    input  logic [LUT_ADDR_W-1:0]       idx,
    output logic signed [DDS_WIDTH-1:0] cos_out,
    output logic signed [DDS_WIDTH-1:0] sin_out
);

    localparam int RW      = LUT_ADDR_W - 2;
    localparam int QUARTER = 2 ** RW;

    typedef logic [QUARTER*DDS_WIDTH-1:0] table_t;

    function automatic table_t build_table();
        table_t t;
        real    amp;
        real    ang;
        t   = '0;
        amp = real'((2 ** (DDS_WIDTH - 1)) - 1);
        for (int k = 0; k < QUARTER; k++) begin
            ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(4 * QUARTER);
            t[k*DDS_WIDTH +: DDS_WIDTH] = DDS_WIDTH'($rtoi(amp * $cos(ang) + 0.5));
        end
        return t;
    endfunction

    localparam table_t TABLE = build_table();

    quadrant_t                    quad;
    logic [RW-1:0]                r;
    logic [RW-1:0]                r_mirror;
    logic signed [DDS_WIDTH-1:0]  c_q;
    logic signed [DDS_WIDTH-1:0]  s_q;
    logic signed [DDS_WIDTH-1:0]  cos_nx;
    logic signed [DDS_WIDTH-1:0]  sin_nx;

    // sin of the in-quadrant angle is the table read backwards; r = 0 maps to
    // the quarter point, which is not stored and is exactly zero.
    always_comb begin
        quad     = quadrant_t'(idx[LUT_ADDR_W-1 -: 2]);
        r        = idx[RW-1:0];
        r_mirror = -r;
        c_q      = TABLE[int'(r)*DDS_WIDTH +: DDS_WIDTH];
        s_q      = (r == '0) ? '0 : TABLE[int'(r_mirror)*DDS_WIDTH +: DDS_WIDTH];
        cos_nx   = c_q;
        sin_nx   = s_q;
        case (quad)
            Q0: begin cos_nx = c_q;  sin_nx = s_q;  end
            Q1: begin cos_nx = -s_q; sin_nx = c_q;  end
            Q2: begin cos_nx = -c_q; sin_nx = -s_q; end
            Q3: begin cos_nx = s_q;  sin_nx = -c_q; end
            default: begin cos_nx = c_q; sin_nx = s_q; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (en) begin
            cos_out <= cos_nx;
            sin_out <= sin_nx;
        end
    end

endmodule

// File: rtl/tx_rotator.sv
// Transmit complex rotator: NCO phase accumulator plus a 4-stage multiply
// pipeline rotating I/Q by e^(+j*theta), with valid/ready flow control.
module tx_rotator
    import msk_tx_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int DDS_WIDTH   = DDS_WIDTH_DEF,
    parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
    parameter int LUT_ADDR_W  = LUT_ADDR_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PHASE_WIDTH-1:0]  freq_word,
    input  logic                    phase_clr,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [WIDTH-1:0] din_i,
    input  logic signed [WIDTH-1:0] din_q,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [WIDTH-1:0] dout_i,
    output logic signed [WIDTH-1:0] dout_q
);

    localparam int PW = WIDTH + DDS_WIDTH;
    localparam int SW = PW + 1;

    logic                        en;
    logic                        accept;
    logic [PHASE_WIDTH-1:0]      acc;
    logic [LUT_ADDR_W-1:0]       idx_nx;

    logic                        v1, v2, v3;
    logic signed [WIDTH-1:0]     i1, q1, i2, q2;
    logic [LUT_ADDR_W-1:0]       idx1;
    logic signed [DDS_WIDTH-1:0] cos2, sin2;
    logic signed [PW-1:0]        p_ic, p_qs, p_is, p_qc;
    logic signed [SW-1:0]        sum_i, sum_q;
    logic signed [WIDTH-1:0]     sat_i, sat_q;

    assign en      = !m_valid || m_ready;
    assign s_ready = en;
    assign accept  = s_valid && en;
    assign idx_nx  = phase_clr ? '0 : acc[PHASE_WIDTH-1 -: LUT_ADDR_W];

    // The sample accepted with phase_clr sees phase 0, so the next one sees freq_word.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (accept) begin
            acc <= phase_clr ? freq_word : acc + freq_word;
        end else if (phase_clr) begin
            acc <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            i1   <= din_i;
            q1   <= din_q;
            idx1 <= idx_nx;
            i2   <= i1;
            q2   <= q1;
            p_ic <= PW'(i2) * PW'(cos2);
            p_qs <= PW'(q2) * PW'(sin2);
            p_is <= PW'(i2) * PW'(sin2);
            p_qc <= PW'(q2) * PW'(cos2);
        end
    end

    tx_sincos_lut #(
        .DDS_WIDTH  (DDS_WIDTH),
        .LUT_ADDR_W (LUT_ADDR_W)
    ) u_lut (
        .clk     (clk),
        .en      (en),
        .idx     (idx1),
        .cos_out (cos2),
        .sin_out (sin2)
    );

    always_comb begin
        sum_i = {p_ic[PW-1], p_ic} - {p_qs[PW-1], p_qs};
        sum_q = {p_is[PW-1], p_is} + {p_qc[PW-1], p_qc};
        sat_i = WIDTH'(saturate((64'(sum_i) + round_const(DDS_WIDTH)) >>> (DDS_WIDTH - 1), WIDTH));
        sat_q = WIDTH'(saturate((64'(sum_q) + round_const(DDS_WIDTH)) >>> (DDS_WIDTH - 1), WIDTH));
    end

    // Bubbles load zeros so the output bus is quiet whenever m_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            m_valid <= 1'b0;
            dout_i  <= '0;
            dout_q  <= '0;
        end else if (en) begin
            v1      <= accept;
            v2      <= v1;
            v3      <= v2;
            m_valid <= v3;
            dout_i  <= v3 ? sat_i : '0;
            dout_q  <= v3 ? sat_q : '0;
        end
    end

endmodule

// File: tb/tb_tx_rotator.sv
// Scoreboard bench for tx_rotator: a reference NCO/rotation model queues the
// expected output of every accepted sample and a monitor checks them in order.
module tb_tx_rotator;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        freq_word;
    logic               phase_clr;
    logic               s_valid;
    logic               s_ready;
    logic signed [15:0] din_i, din_q;
    logic               m_valid;
    logic               m_ready;
    logic signed [15:0] dout_i, dout_q;

    always #5 clk = ~clk;

    tx_rotator dut (
        .clk       (clk),
        .rst       (rst),
        .freq_word (freq_word),
        .phase_clr (phase_clr),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .din_i     (din_i),
        .din_q     (din_q),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .dout_i    (dout_i),
        .dout_q    (dout_q)
    );

    typedef struct {
        longint i;
        longint q;
    } samp_t;

    int          checks   = 0;
    int          failures = 0;
    samp_t       sb[$];
    int          cos_tab[1024];
    logic [31:0] acc_m;
    int          stall_cnt;
    logic        mon_en;
    logic        tog_done;

    task automatic check_val(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    function automatic longint sat16(input longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    task automatic push_expected(input int i, input int q, input logic [31:0] fw,
                                 input logic clr);
        logic [31:0] theta;
        int          k;
        longint      c, s, pi_, pq_;
        samp_t       e;
        theta = clr ? 32'd0 : acc_m;
        acc_m = clr ? fw : acc_m + fw;
        k     = int'(theta[31:22]);
        c     = cos_tab[k];
        s     = cos_tab[(k + 768) % 1024];
        pi_   = longint'(i) * c - longint'(q) * s + 16384;
        pq_   = longint'(i) * s + longint'(q) * c + 16384;
        e.i   = sat16(pi_ >>> 15);
        e.q   = sat16(pq_ >>> 15);
        sb.push_back(e);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int i, input int q, input logic [31:0] fw, input logic clr);
        bit accepted;
        accepted  = 0;
        din_i     = 16'(i);
        din_q     = 16'(q);
        freq_word = fw;
        phase_clr = clr;
        s_valid   = 1'b1;
        for (int n = 0; n < 200 && !accepted; n++) begin
            @(negedge clk);
            if (s_ready) begin
                push_expected(i, q, fw, clr);
                accepted = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!accepted) check_val("accept_timeout", 0, 1);
        s_valid   = 1'b0;
        phase_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        acc_m = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && sb.size() != 0; n++) @(posedge clk);
        #1;
        check_val("drain_empty", sb.size(), 0);
    endtask

    // Output monitor: scoreboard compare on each transfer plus hold checks while stalled.
    logic               prev_stall;
    logic signed [15:0] prev_i, prev_q;
    samp_t              mon_e;

    always @(negedge clk) begin
        if (rst || !mon_en) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_val("stall_hold_valid", m_valid, 1);
                check_val("stall_hold_i", dout_i, prev_i);
                check_val("stall_hold_q", dout_q, prev_q);
            end
            if (m_valid && !m_ready) begin
                stall_cnt++;
                check_val("stall_s_ready", s_ready, 0);
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_output", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check_val("dout_i", dout_i, mon_e.i);
                    check_val("dout_q", dout_q, mon_e.q);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_i     = dout_i;
            prev_q     = dout_q;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        for (int k = 0; k < 1024; k++)
            cos_tab[k] = rnd(32767.0 * $cos(2.0 * 3.14159265358979323846 * real'(k) / 1024.0));
        rst       = 1'b1;
        mon_en    = 1'b0;
        s_valid   = 1'b0;
        phase_clr = 1'b0;
        freq_word = '0;
        din_i     = '0;
        din_q     = '0;
        m_ready   = 1'b0;
        acc_m     = '0;
        stall_cnt = 0;
        tog_done  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_m_valid", m_valid, 0);
        check_val("rst_dout_i", dout_i, 0);
        check_val("rst_dout_q", dout_q, 0);
        check_val("rst_s_ready", s_ready, 1);
        rst     = 1'b0;
        m_ready = 1'b1;
        mon_en  = 1'b1;

        // zero frequency with latency measurement
        din_i = 16'sd16384; din_q = 16'sd0; freq_word = 32'd0; s_valid = 1'b1;
        @(negedge clk);
        check_val("first_s_ready", s_ready, 1);
        push_expected(16384, 0, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        lat = 1;
        while (!m_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val("latency", lat, 4);
        for (int k = 0; k < 3; k++) send(16384, 0, 32'd0, 1'b0);
        drain();

        // quarter-turn steps
        do_reset();
        for (int k = 0; k < 8; k++) send(16384, 0, 32'h4000_0000, 1'b0);
        drain();

        // full scale at 45 degrees
        do_reset();
        for (int k = 0; k < 3; k++) send(32767, 32767, 32'h2000_0000, 1'b0);
        drain();

        // backpressure on cycles 5..9 of an 8-sample ramp
        do_reset();
        stall_cnt = 0;
        fork
            for (int k = 0; k < 8; k++) send(k * 1000 - 3000, 2000 - k * 500, 32'h1000_0000, 1'b0);
            for (int c = 0; c < 16; c++) begin
                m_ready = !(c >= 5 && c <= 9);
                @(posedge clk);
                #1;
            end
        join
        m_ready = 1'b1;
        drain();
        check_val("stall_seen", stall_cnt > 0, 1);

        // phase_clr on the third sample
        do_reset();
        for (int k = 0; k < 5; k++) send(1000 * (k + 1), 300, 32'h4000_0000, k == 2);
        drain();

        // reset with three samples in flight
        do_reset();
        for (int k = 0; k < 3; k++) send(12000, -4000, 32'h0800_0000, 1'b0);
        do_reset();
        for (int c = 0; c < 5; c++) begin
            check_val("flush_m_valid", m_valid, 0);
            check_val("flush_dout_i", dout_i, 0);
            check_val("flush_dout_q", dout_q, 0);
            @(posedge clk);
            #1;
        end
        send(5000, -7000, 32'h4000_0000, 1'b0);
        drain();

        // random data, odd frequency word, random backpressure
        do_reset();
        fork
            begin
                for (int k = 0; k < 24; k++)
                    send(int'($urandom_range(0, 65535)) - 32768,
                         int'($urandom_range(0, 65535)) - 32768, 32'h0123_4567, 1'b0);
                tog_done = 1'b1;
            end
            while (!tog_done) begin
                m_ready = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
        join
        m_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
